dm_stage: RTL and testbench

- Data-memory stage of the 5-stage MIPS pipeline. Sits between the EX→MEM register and the MEM2WB register.
- Performs word, halfword and byte loads and stores against an internal word-organised RAM.
- Produces the load result (DM_RD_3) consumed by MEM2WB, flags address exceptions, and registers a store trace for the testbench.

---
 rtl/dm_stage.sv | 124 ++++++++++++
 tb/tb_dm_stage.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/dm_stage.sv
// dm_stage: MEM-stage data memory; word/half/byte loads and stores on a word-organised RAM, plus a store trace.
// Latency: loads are combinational (0 cycles); stores and the store trace commit on the rising clk edge.
// Backpressure: none; a stall upstream simply deasserts MemWrite_3 / MemRead_3.
module dm_stage #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] PC_3,
    input  logic [31:0] Addr_3,
    input  logic [31:0] WD_3,
    input  logic        MemRead_3,
    input  logic        MemWrite_3,
    input  logic [2:0]  MemOp_3,
    output logic [31:0] DM_RD_3,
    output logic        AdEL_3,
    output logic        AdES_3,
    output logic        StoreValid,
    output logic [31:0] StorePC,
    output logic [31:0] StoreAddr,
    output logic [31:0] StoreData
);
    localparam int unsigned AW         = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN_BYTES = 32'(DEPTH_WORDS * 4);

    logic [31:0]   mem_q [DEPTH_WORDS];
    logic [31:0]   mem_d [DEPTH_WORDS];
    logic          store_valid_q, store_valid_d;
    logic [31:0]   store_pc_q, store_pc_d;
    logic [31:0]   store_addr_q, store_addr_d;
    logic [31:0]   store_data_q, store_data_d;

    logic [31:0]   off;
    logic [AW-1:0] idx;
    logic          op_word, op_half, op_byte, op_signed, op_illegal;
    logic          fault, st_en;
    logic [31:0]   rd_word, ld_val, merged;
    logic [15:0]   ld_half;
    logic [7:0]    ld_byte;

    // Address decode and fault detection; addresses below the base wrap to a large offset and fault.
    always_comb begin
        off        = Addr_3 - ADDR_BASE;
        idx        = off[AW+1:2];
        op_word    = (MemOp_3 == 3'b000);
        op_half    = (MemOp_3 == 3'b001) || (MemOp_3 == 3'b010);
        op_byte    = (MemOp_3 == 3'b011) || (MemOp_3 == 3'b100);
        op_signed  = (MemOp_3 == 3'b010) || (MemOp_3 == 3'b100);
        op_illegal = (MemOp_3 > 3'b100);
        fault      = op_illegal || (off >= SPAN_BYTES)
                     || (op_word && (off[1:0] != 2'b00))
                     || (op_half && off[0]);
        st_en      = MemWrite_3 && !fault;
        rd_word    = mem_q[idx];
    end

    // Combinational load: lane select, extension, and exception flags (store wins when both enables are set).
    always_comb begin
        ld_half = off[1] ? rd_word[31:16] : rd_word[15:0];
        ld_byte = rd_word[{off[1:0], 3'b000} +: 8];
        ld_val  = '0;
        if (op_word) begin
            ld_val = rd_word;
        end else if (op_half) begin
            ld_val = {{16{op_signed & ld_half[15]}}, ld_half};
        end else if (op_byte) begin
            ld_val = {{24{op_signed & ld_byte[7]}}, ld_byte};
        end
        DM_RD_3 = (MemRead_3 && !fault) ? ld_val : '0;
        AdEL_3  = MemRead_3 && !MemWrite_3 && fault;
        AdES_3  = MemWrite_3 && fault;
    end

    // Store merge: new lanes overlaid on the current word, other lanes preserved.
    always_comb begin
        merged = rd_word;
        if (op_word) begin
            merged = WD_3;
        end else if (op_half) begin
            if (off[1]) merged[31:16] = WD_3[15:0];
            else        merged[15:0]  = WD_3[15:0];
        end else if (op_byte) begin
            merged[{off[1:0], 3'b000} +: 8] = WD_3[7:0];
        end
    end

    // Next-state for RAM and store trace; trace payload holds when no store commits.
    always_comb begin
        mem_d = mem_q;
        if (st_en) mem_d[idx] = merged;
        store_valid_d = st_en;
        store_pc_d    = store_pc_q;
        store_addr_d  = store_addr_q;
        store_data_d  = store_data_q;
        if (st_en) begin
            store_pc_d   = PC_3;
            store_addr_d = ADDR_BASE + {{(30-AW){1'b0}}, idx, 2'b00};
            store_data_d = merged;
        end
    end

    // State registers; reset clears the RAM and trace immediately and discards a coinciding store.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH_WORDS; i++) mem_q[i] <= '0;
            store_valid_q <= 1'b0;
            store_pc_q    <= '0;
            store_addr_q  <= '0;
            store_data_q  <= '0;
        end else begin
            mem_q         <= mem_d;
            store_valid_q <= store_valid_d;
            store_pc_q    <= store_pc_d;
            store_addr_q  <= store_addr_d;
            store_data_q  <= store_data_d;
        end
    end

    assign StoreValid = store_valid_q;
    assign StorePC    = store_pc_q;
    assign StoreAddr  = store_addr_q;
    assign StoreData  = store_data_q;
endmodule

// File: tb/tb_dm_stage.sv
// tb_dm_stage: byte-addressed reference model feeding an expectation queue; a negedge monitor compares.
// Latency: inputs driven 2 time units after each rising edge, checked on the following falling edge.
// Backpressure: not applicable; one expectation per cycle.
module tb_dm_stage;
    localparam int unsigned DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam int unsigned SPAN  = DEPTH * 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] PC_3, Addr_3, WD_3;
    logic        MemRead_3, MemWrite_3;
    logic [2:0]  MemOp_3;
    logic [31:0] DM_RD_3;
    logic        AdEL_3, AdES_3;
    logic        StoreValid;
    logic [31:0] StorePC, StoreAddr, StoreData;

    always #5 clk = ~clk;

    dm_stage #(.DEPTH_WORDS(DEPTH), .ADDR_BASE(BASE)) dut (
        .clk(clk), .reset(reset), .PC_3(PC_3), .Addr_3(Addr_3), .WD_3(WD_3),
        .MemRead_3(MemRead_3), .MemWrite_3(MemWrite_3), .MemOp_3(MemOp_3),
        .DM_RD_3(DM_RD_3), .AdEL_3(AdEL_3), .AdES_3(AdES_3),
        .StoreValid(StoreValid), .StorePC(StorePC), .StoreAddr(StoreAddr), .StoreData(StoreData)
    );

    typedef struct {
        logic [31:0] rd;
        logic        adel;
        logic        ades;
        logic        sv;
        logic        rst_chk;
        int          tag;
    } exp_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] data;
    } trc_t;

    exp_t        exp_q[$];
    trc_t        trc_q[$];
    byte unsigned model_mem [SPAN];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic        prev_store = 1'b0;

    task automatic chk(input int tag, input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s tag=%0d actual=%h expected=%h", nm, tag, act, expv);
        end
    endtask

    // Access size in bytes; 0 marks an illegal operation code.
    function automatic int size_of(input logic [2:0] op);
        case (op)
            3'd0:       return 4;
            3'd1, 3'd2: return 2;
            3'd3, 3'd4: return 1;
            default:    return 0;
        endcase
    endfunction

    function automatic logic model_fault(input logic [31:0] a, input logic [2:0] op);
        logic [31:0] o;
        int          sz;
        o  = a - BASE;
        sz = size_of(op);
        if (sz == 0) return 1'b1;
        if (o >= SPAN) return 1'b1;
        if ((o % sz) != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [2:0] op);
        logic [31:0] o, v;
        o = a - BASE;
        v = 32'h0;
        for (int k = 0; k < size_of(op); k++) v = v | (32'(model_mem[o + k]) << (8 * k));
        if (op == 3'd2 && v[15]) v = v | 32'hFFFF_0000;
        if (op == 3'd4 && v[7])  v = v | 32'hFFFF_FF00;
        return v;
    endfunction

    // Writes the access bytes little-endian and returns the whole containing word afterwards.
    function automatic logic [31:0] model_store(input logic [31:0] a, input logic [2:0] op, input logic [31:0] wd);
        logic [31:0] o, w, wa;
        o = a - BASE;
        for (int k = 0; k < size_of(op); k++) model_mem[o + k] = wd[8*k +: 8];
        wa = o & 32'hFFFF_FFFC;
        w  = 32'h0;
        for (int k = 0; k < 4; k++) w = w | (32'(model_mem[wa + k]) << (8 * k));
        return w;
    endfunction

    task automatic assert_reset();
        reset = 1'b1;
        for (int i = 0; i < int'(SPAN); i++) model_mem[i] = 8'h00;
        trc_q.delete();
        prev_store = 1'b0;
    endtask

    // One cycle: drive at posedge+2, queue expectation, cross the edge, commit the store in the model.
    task automatic step(input logic rd, input logic wr, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] wd, input int tag);
        exp_t        e;
        trc_t        t;
        logic        f;
        logic [31:0] pc;
        pc         = 32'h0040_0000 + 32'(tag) * 4;
        MemRead_3  = rd;
        MemWrite_3 = wr;
        MemOp_3    = op;
        Addr_3     = a;
        WD_3       = wd;
        PC_3       = pc;
        f          = model_fault(a, op);
        e.rd       = (rd && !f) ? model_load(a, op) : 32'h0;
        e.adel     = rd && !wr && f;
        e.ades     = wr && f;
        e.sv       = prev_store && !reset;
        e.rst_chk  = reset;
        e.tag      = tag;
        exp_q.push_back(e);
        @(posedge clk);
        prev_store = 1'b0;
        if (wr && !f && !reset) begin
            t.pc   = pc;
            t.addr = BASE + ((a - BASE) & 32'hFFFF_FFFC);
            t.data = model_store(a, op, wd);
            trc_q.push_back(t);
            prev_store = 1'b1;
        end
        #2;
    endtask

    // Monitor: pops one expectation per falling edge and compares all outputs.
    initial begin
        exp_t e;
        trc_t t;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk(e.tag, "DM_RD_3", DM_RD_3, e.rd);
                chk(e.tag, "AdEL_3", 32'(AdEL_3), 32'(e.adel));
                chk(e.tag, "AdES_3", 32'(AdES_3), 32'(e.ades));
                chk(e.tag, "StoreValid", 32'(StoreValid), 32'(e.sv));
                if (StoreValid === 1'b1) begin
                    if (trc_q.size() == 0) begin
                        chk(e.tag, "spurious_store_trace", 32'(trc_q.size()), 32'd1);
                    end else begin
                        t = trc_q.pop_front();
                        chk(e.tag, "StorePC", StorePC, t.pc);
                        chk(e.tag, "StoreAddr", StoreAddr, t.addr);
                        chk(e.tag, "StoreData", StoreData, t.data);
                    end
                end
                if (e.rst_chk) begin
                    chk(e.tag, "StorePC_rst", StorePC, 32'h0);
                    chk(e.tag, "StoreAddr_rst", StoreAddr, 32'h0);
                    chk(e.tag, "StoreData_rst", StoreData, 32'h0);
                end
            end
        end
    end

    initial begin
        logic [31:0] a;
        logic [2:0]  op;
        int          sel;
        MemRead_3 = 1'b0; MemWrite_3 = 1'b0; MemOp_3 = 3'd0;
        Addr_3 = 32'h0; WD_3 = 32'h0; PC_3 = 32'h0;
        assert_reset();
        @(posedge clk);
        #2;
        // Reset state, load during reset sees cleared RAM.
        step(1, 0, 3'd0, 32'h10, 32'h0, 1);
        reset = 1'b0;
        // Word store then load, with trace.
        step(0, 1, 3'd0, 32'h10, 32'hDEAD_BEEF, 2);
        step(1, 0, 3'd0, 32'h10, 32'h0, 3);
        // Sub-word loads.
        step(1, 0, 3'd4, 32'h13, 32'h0, 4);
        step(1, 0, 3'd3, 32'h13, 32'h0, 5);
        step(1, 0, 3'd2, 32'h10, 32'h0, 6);
        step(1, 0, 3'd1, 32'h12, 32'h0, 7);
        // Byte and half merges.
        step(0, 1, 3'd3, 32'h11, 32'h0000_0011, 8);
        step(0, 1, 3'd1, 32'h12, 32'h0000_2233, 9);
        step(1, 0, 3'd0, 32'h10, 32'h0, 10);
        // Faults.
        step(1, 0, 3'd0, 32'h02, 32'h0, 11);
        step(0, 1, 3'd1, 32'h01, 32'h0000_ABCD, 12);
        step(1, 0, 3'd0, 32'h00, 32'h0, 13);
        step(1, 0, 3'd0, 32'(SPAN), 32'h0, 14);
        step(1, 0, 3'd7, 32'h10, 32'h0, 15);
        step(1, 0, 3'd5, 32'h10, 32'h0, 16);
        step(0, 1, 3'd0, 32'hFFFF_FFFC, 32'h1234_5678, 17);
        // Same-cycle store and load to one word: pre-edge contents, then the new word.
        step(0, 1, 3'd0, 32'h20, 32'h1, 18);
        step(1, 1, 3'd0, 32'h20, 32'h5, 19);
        step(1, 0, 3'd0, 32'h20, 32'h0, 20);
        // Randomized traffic, mostly in a small window, with edge addresses and occasional resets.
        for (int n = 0; n < 400; n++) begin
            sel = $urandom_range(0, 9);
            if (sel < 7)       a = BASE + 32'($urandom_range(0, 63));
            else if (sel < 9)  a = BASE + 32'(SPAN) - 32'd8 + 32'($urandom_range(0, 15));
            else               a = $urandom;
            op = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
            if ($urandom_range(0, 49) == 0) assert_reset();
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), op, a, $urandom, 100 + n);
            reset = 1'b0;
        end
        // Mid-cycle asynchronous reset after several stores, then a store held across an edge in reset.
        step(0, 1, 3'd0, 32'h40, 32'hAAAA_5555, 600);
        step(0, 1, 3'd0, 32'h44, 32'h1357_9BDF, 601);
        step(0, 1, 3'd3, 32'h48, 32'h0000_00C3, 602);
        assert_reset();
        step(1, 0, 3'd0, 32'h44, 32'h0, 603);
        step(0, 1, 3'd0, 32'h40, 32'hFEED_F00D, 604);
        reset = 1'b0;
        step(1, 0, 3'd0, 32'h40, 32'h0, 605);
        step(1, 0, 3'd0, 32'h48, 32'h0, 606);
        step(0, 0, 3'd0, 32'h0, 32'h0, 607);
        @(negedge clk);
        @(negedge clk);
        chk(9998, "pending_expectations", 32'(exp_q.size()), 32'd0);
        chk(9999, "unseen_store_traces", 32'(trc_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
